// File: rtl/rob_pkg.sv
// Shared reorder-buffer types: op encodings, field widths and the per-entry record.
package rob_pkg;

    localparam int unsigned OP_W  = 3;
    localparam int unsigned LSB_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ALU    = 3'd0,
        OP_LOAD   = 3'd1,
        OP_STORE  = 3'd2,
        OP_BRANCH = 3'd3,
        OP_JAL    = 3'd4,
        OP_JALR   = 3'd5
    } op_e;

    typedef struct packed {
        op_e              op;
        logic [4:0]       rd;
        logic [LSB_W-1:0] lsbpos;
        logic [31:0]      val;
        logic             redirect;
        logic [31:0]      target;
        logic             ready;
    } rob_entry_t;

    function automatic logic writes_rd(op_e op);
        return op inside {OP_ALU, OP_LOAD, OP_JAL, OP_JALR};
    endfunction

    function automatic logic is_ctrl(op_e op);
        return op inside {OP_BRANCH, OP_JAL, OP_JALR};
    endfunction

endpackage

// File: rtl/rob_multi_commit_if.sv
// Allocate / writeback / query / commit bundle of the multi-commit reorder buffer.
interface rob_multi_commit_if
    import rob_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned NWB   = 2,
    parameter int unsigned NCMT  = 2
);
    localparam int unsigned TAG_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = TAG_W + 1;

    logic                   alloc_valid;
    logic                   alloc_ready;
    op_e                    alloc_op;
    logic [4:0]             alloc_rd;
    logic [31:0]            alloc_pc;
    logic [LSB_W-1:0]       alloc_lsbpos;
    logic [TAG_W-1:0]       alloc_tag;

    logic [NWB-1:0]         wb_valid;
    logic [NWB*TAG_W-1:0]   wb_tag;
    logic [NWB*32-1:0]      wb_val;
    logic [NWB-1:0]         wb_redirect;
    logic [NWB*32-1:0]      wb_target;

    logic [1:0]             q_valid;
    logic [1:0][TAG_W-1:0]  q_tag;
    logic [1:0]             q_ok;
    logic [1:0][31:0]       q_val;

    logic [NCMT-1:0]        cmt_valid;
    logic [NCMT*5-1:0]      cmt_rd;
    logic [NCMT*TAG_W-1:0]  cmt_tag;
    logic [NCMT*32-1:0]     cmt_val;

    logic                   st_commit;
    logic [LSB_W-1:0]       st_lsbpos;
    logic                   flush;
    logic [31:0]            flush_pc;
    logic [CNT_W-1:0]       count;

    modport master (
        output alloc_valid, alloc_op, alloc_rd, alloc_pc, alloc_lsbpos,
        output wb_valid, wb_tag, wb_val, wb_redirect, wb_target,
        output q_valid, q_tag,
        input  alloc_ready, alloc_tag, q_ok, q_val,
        input  cmt_valid, cmt_rd, cmt_tag, cmt_val,
        input  st_commit, st_lsbpos, flush, flush_pc, count
    );

    modport slave (
        input  alloc_valid, alloc_op, alloc_rd, alloc_pc, alloc_lsbpos,
        input  wb_valid, wb_tag, wb_val, wb_redirect, wb_target,
        input  q_valid, q_tag,
        output alloc_ready, alloc_tag, q_ok, q_val,
        output cmt_valid, cmt_rd, cmt_tag, cmt_val,
        output st_commit, st_lsbpos, flush, flush_pc, count
    );

endinterface

// File: rtl/rob_commit_sel.sv
// Picks the longest committable run from the head window: stops at a non-ready
// entry, at a second store, or just after a redirecting branch/jump.
module rob_commit_sel
    import rob_pkg::*;
#(
    parameter int unsigned NCMT  = 2,
    parameter int unsigned CNT_W = 5
) (
    input  logic [CNT_W-1:0] count,
    input  logic [NCMT-1:0]  ready,
    input  logic [NCMT-1:0]  redirect,
    input  op_e              op [NCMT],
    output logic [NCMT-1:0]  take_c,
    output logic [CNT_W-1:0] ncommit_c
);

    logic stop;
    logic seen_st;

    always_comb begin
        take_c    = '0;
        ncommit_c = '0;
        stop      = 1'b0;
        seen_st   = 1'b0;
        for (int k = 0; k < int'(NCMT); k++) begin
            if (!stop) begin
                if (CNT_W'(k) >= count || !ready[k] || (op[k] == OP_STORE && seen_st)) begin
                    stop = 1'b1;
                end else begin
                    take_c[k] = 1'b1;
                    ncommit_c = ncommit_c + CNT_W'(1);
                    if (op[k] == OP_STORE) seen_st = 1'b1;
                    if (is_ctrl(op[k]) && redirect[k]) stop = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rob_multi_commit.sv
// Reorder buffer with multi-entry in-order commit, store/flush pulses and operand query.
// Define ROB_WB_BYPASS_EN to forward same-cycle writeback values to the query port.
module rob_multi_commit
    import rob_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned NWB   = 2,
    parameter int unsigned NCMT  = 2
) (
    input logic               clk,
    input logic               reset,
    input logic               en,
    rob_multi_commit_if.slave bus
);

    localparam int unsigned TAG_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = TAG_W + 1;

    rob_entry_t       rob_q [DEPTH];
    logic [TAG_W-1:0] head_q;
    logic [TAG_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    logic             flush_q;

    logic [TAG_W-1:0] win_idx [NCMT];
    op_e              win_op  [NCMT];
    logic [NCMT-1:0]  win_ready;
    logic [NCMT-1:0]  win_redirect;
    logic [NCMT-1:0]  take_c;
    logic [CNT_W-1:0] ncommit_c;

    logic             alloc_ready_c;
    logic             alloc_fire_c;
    logic [NCMT-1:0]  cmt_valid_c;
    logic             st_c;
    logic [LSB_W-1:0] st_lsb_c;
    logic             flush_c;
    logic [31:0]      flush_pc_c;
    logic [1:0]       q_ok_c;
    logic [1:0][31:0] q_val_c;

    // The allocation pc is kept on the bus for tracing; nothing here consumes it.
    logic unused_alloc_pc;
    assign unused_alloc_pc = ^bus.alloc_pc;

    always_comb begin
        for (int k = 0; k < int'(NCMT); k++) begin
            win_idx[k]      = head_q + TAG_W'(k);
            win_op[k]       = rob_q[win_idx[k]].op;
            win_ready[k]    = rob_q[win_idx[k]].ready;
            win_redirect[k] = rob_q[win_idx[k]].redirect;
        end
    end

    rob_commit_sel #(.NCMT(NCMT), .CNT_W(CNT_W)) u_commit_sel (
        .count     (count_q),
        .ready     (win_ready),
        .redirect  (win_redirect),
        .op        (win_op),
        .take_c    (take_c),
        .ncommit_c (ncommit_c)
    );

    // Decode the selected run into commit, store and redirect pulses.
    always_comb begin
        cmt_valid_c = '0;
        st_c        = 1'b0;
        st_lsb_c    = '0;
        flush_c     = 1'b0;
        flush_pc_c  = '0;
        for (int k = 0; k < int'(NCMT); k++) begin
            if (take_c[k]) begin
                cmt_valid_c[k] = writes_rd(win_op[k]);
                if (win_op[k] == OP_STORE) begin
                    st_c     = 1'b1;
                    st_lsb_c = rob_q[win_idx[k]].lsbpos;
                end
                if (is_ctrl(win_op[k]) && win_redirect[k]) begin
                    flush_c    = 1'b1;
                    flush_pc_c = rob_q[win_idx[k]].target;
                end
            end
        end
    end

    assign alloc_ready_c = (count_q < CNT_W'(DEPTH)) && !flush_q;
    assign alloc_fire_c  = bus.alloc_valid && alloc_ready_c && en && !flush_c;

    assign bus.alloc_ready = alloc_ready_c;
    assign bus.alloc_tag   = tail_q;
    assign bus.count       = count_q;
    assign bus.flush       = flush_q;

    // Operand query; the optional bypass lets the highest matching channel override.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            q_ok_c[i]  = bus.q_valid[i] && rob_q[bus.q_tag[i]].ready;
            q_val_c[i] = rob_q[bus.q_tag[i]].val;
`ifdef ROB_WB_BYPASS_EN
            for (int j = 0; j < int'(NWB); j++) begin
                if (bus.q_valid[i] && bus.wb_valid[j] && bus.wb_tag[j*TAG_W +: TAG_W] == bus.q_tag[i]) begin
                    q_ok_c[i]  = 1'b1;
                    q_val_c[i] = bus.wb_val[j*32 +: 32];
                end
            end
`endif
        end
    end

    assign bus.q_ok  = q_ok_c;
    assign bus.q_val = q_val_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            flush_q       <= 1'b0;
            bus.cmt_valid <= '0;
            bus.st_commit <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) rob_q[i].ready <= 1'b0;
        end else if (!en) begin
            bus.cmt_valid <= '0;
            bus.st_commit <= 1'b0;
            flush_q       <= 1'b0;
        end else begin
            bus.cmt_valid <= cmt_valid_c;
            bus.st_commit <= st_c;
            flush_q       <= flush_c;
            if (st_c)    bus.st_lsbpos <= st_lsb_c;
            if (flush_c) bus.flush_pc  <= flush_pc_c;
            for (int k = 0; k < int'(NCMT); k++) begin
                bus.cmt_rd[k*5 +: 5]          <= rob_q[win_idx[k]].rd;
                bus.cmt_tag[k*TAG_W +: TAG_W] <= win_idx[k];
                bus.cmt_val[k*32 +: 32]       <= rob_q[win_idx[k]].val;
            end
            if (alloc_fire_c) begin
                rob_q[tail_q] <= '{op: bus.alloc_op, rd: bus.alloc_rd, lsbpos: bus.alloc_lsbpos,
                                   val: 32'd0, redirect: 1'b0, target: 32'd0,
                                   ready: (bus.alloc_op == OP_STORE)};
            end
            // Later channels overwrite earlier ones on a shared tag.
            for (int j = 0; j < int'(NWB); j++) begin
                if (bus.wb_valid[j]) begin
                    rob_q[bus.wb_tag[j*TAG_W +: TAG_W]].val      <= bus.wb_val[j*32 +: 32];
                    rob_q[bus.wb_tag[j*TAG_W +: TAG_W]].redirect <= bus.wb_redirect[j];
                    rob_q[bus.wb_tag[j*TAG_W +: TAG_W]].target   <= bus.wb_target[j*32 +: 32];
                    rob_q[bus.wb_tag[j*TAG_W +: TAG_W]].ready    <= 1'b1;
                end
            end
            if (flush_c) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                head_q  <= head_q + TAG_W'(ncommit_c);
                tail_q  <= tail_q + TAG_W'(alloc_fire_c);
                count_q <= count_q + CNT_W'(alloc_fire_c) - ncommit_c;
            end
        end
    end

endmodule

// File: tb/tb_rob_multi_commit.sv
// Randomised and directed bench for rob_multi_commit against an in-order queue model.
module tb_rob_multi_commit;
    import rob_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned NWB   = 2;
    localparam int unsigned NCMT  = 2;
    localparam int unsigned TAG_W = 4;

    logic clk = 1'b0;
    logic reset;
    logic en;
    always #5 clk = ~clk;

    rob_multi_commit_if #(.DEPTH(DEPTH), .NWB(NWB), .NCMT(NCMT)) bus ();

    rob_multi_commit #(.DEPTH(DEPTH), .NWB(NWB), .NCMT(NCMT)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .bus   (bus.slave)
    );

    int vectors;
    int miscompares;

    // reference state: per-tag entry contents plus head/occupancy of the live window
    op_e         m_op   [DEPTH];
    logic [4:0]  m_rd   [DEPTH];
    logic [3:0]  m_lsb  [DEPTH];
    logic [31:0] m_val  [DEPTH];
    logic [31:0] m_tgt  [DEPTH];
    bit          m_rdy  [DEPTH];
    bit          m_redir[DEPTH];
    int          m_head;
    int          m_cnt;

    bit              e_flush;
    logic [31:0]     e_flush_pc;
    bit              e_st;
    logic [3:0]      e_st_lsb;
    logic [NCMT-1:0] e_cmt_valid;
    logic [4:0]      e_cmt_rd  [NCMT];
    logic [3:0]      e_cmt_tag [NCMT];
    logic [31:0]     e_cmt_val [NCMT];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        reset            = 1'b0;
        en               = 1'b1;
        bus.alloc_valid  = 1'b0;
        bus.alloc_op     = OP_ALU;
        bus.alloc_rd     = '0;
        bus.alloc_pc     = '0;
        bus.alloc_lsbpos = '0;
        bus.wb_valid     = '0;
        bus.wb_tag       = '0;
        bus.wb_val       = '0;
        bus.wb_redirect  = '0;
        bus.wb_target    = '0;
        bus.q_valid      = '0;
        bus.q_tag        = '0;
    endtask

    task automatic set_alloc(input op_e op, input logic [4:0] rd, input logic [3:0] lsb);
        bus.alloc_valid  = 1'b1;
        bus.alloc_op     = op;
        bus.alloc_rd     = rd;
        bus.alloc_lsbpos = lsb;
        bus.alloc_pc     = $urandom;
    endtask

    task automatic set_wb(input int ch, input int tag, input logic [31:0] val,
                          input bit redir, input logic [31:0] tgt);
        bus.wb_valid[ch]                  = 1'b1;
        bus.wb_tag[ch*TAG_W +: TAG_W]     = TAG_W'(tag);
        bus.wb_val[ch*32 +: 32]           = val;
        bus.wb_redirect[ch]               = redir;
        bus.wb_target[ch*32 +: 32]        = tgt;
    endtask

    function automatic bit rd_writer(input op_e op);
        return op == OP_ALU || op == OP_LOAD || op == OP_JAL || op == OP_JALR;
    endfunction

    function automatic bit ctrl_op(input op_e op);
        return op == OP_BRANCH || op == OP_JAL || op == OP_JALR;
    endfunction

    task automatic check_comb();
        bit          ar;
        bit          ok;
        logic [31:0] v;
        int          t;
        ar = (m_cnt < int'(DEPTH)) && !e_flush;
        check("alloc_ready", 32'(bus.alloc_ready), 32'(ar));
        if (ar) check("alloc_tag", 32'(bus.alloc_tag), 32'((m_head + m_cnt) % int'(DEPTH)));
        for (int i = 0; i < 2; i++) begin
            t  = int'(bus.q_tag[i]);
            ok = bus.q_valid[i] && m_rdy[t];
            v  = m_val[t];
`ifdef ROB_WB_BYPASS_EN
            for (int j = 0; j < int'(NWB); j++) begin
                if (bus.q_valid[i] && bus.wb_valid[j] && int'(bus.wb_tag[j*TAG_W +: TAG_W]) == t) begin
                    ok = 1'b1;
                    v  = bus.wb_val[j*32 +: 32];
                end
            end
`endif
            check($sformatf("q_ok%0d", i), 32'(bus.q_ok[i]), 32'(ok));
            if (ok) check($sformatf("q_val%0d", i), bus.q_val[i], v);
        end
    endtask

    // Applies the commit/alloc/writeback rules of one clock edge to the model.
    task automatic model_step();
        bit ar;
        bit alloc;
        bit seen_st;
        int n;
        int t;
        int tail;
        ar          = (m_cnt < int'(DEPTH)) && !e_flush;
        e_cmt_valid = '0;
        e_st        = 1'b0;
        e_flush     = 1'b0;
        if (reset) begin
            m_head = 0;
            m_cnt  = 0;
            for (int i = 0; i < int'(DEPTH); i++) m_rdy[i] = 1'b0;
            return;
        end
        if (!en) return;
        n       = 0;
        seen_st = 1'b0;
        for (int k = 0; k < int'(NCMT); k++) begin
            if (k >= m_cnt) break;
            t = (m_head + k) % int'(DEPTH);
            if (!m_rdy[t]) break;
            if (m_op[t] == OP_STORE) begin
                if (seen_st) break;
                seen_st  = 1'b1;
                e_st     = 1'b1;
                e_st_lsb = m_lsb[t];
            end
            if (rd_writer(m_op[t])) begin
                e_cmt_valid[k] = 1'b1;
                e_cmt_rd[k]    = m_rd[t];
                e_cmt_tag[k]   = TAG_W'(t);
                e_cmt_val[k]   = m_val[t];
            end
            n++;
            if (ctrl_op(m_op[t]) && m_redir[t]) begin
                e_flush    = 1'b1;
                e_flush_pc = m_tgt[t];
                break;
            end
        end
        tail  = (m_head + m_cnt) % int'(DEPTH);
        alloc = bus.alloc_valid && ar && !e_flush;
        if (alloc) begin
            m_op[tail]    = bus.alloc_op;
            m_rd[tail]    = bus.alloc_rd;
            m_lsb[tail]   = bus.alloc_lsbpos;
            m_val[tail]   = 32'd0;
            m_redir[tail] = 1'b0;
            m_rdy[tail]   = (bus.alloc_op == OP_STORE);
        end
        for (int j = 0; j < int'(NWB); j++) begin
            if (bus.wb_valid[j]) begin
                t          = int'(bus.wb_tag[j*TAG_W +: TAG_W]);
                m_val[t]   = bus.wb_val[j*32 +: 32];
                m_redir[t] = bus.wb_redirect[j];
                m_tgt[t]   = bus.wb_target[j*32 +: 32];
                m_rdy[t]   = 1'b1;
            end
        end
        if (e_flush) begin
            m_head = 0;
            m_cnt  = 0;
        end else begin
            m_head = (m_head + n) % int'(DEPTH);
            m_cnt  = m_cnt + (alloc ? 1 : 0) - n;
        end
    endtask

    task automatic check_regs();
        check("count", 32'(bus.count), 32'(m_cnt));
        check("flush", 32'(bus.flush), 32'(e_flush));
        if (e_flush) check("flush_pc", bus.flush_pc, e_flush_pc);
        check("st_commit", 32'(bus.st_commit), 32'(e_st));
        if (e_st) check("st_lsbpos", 32'(bus.st_lsbpos), 32'(e_st_lsb));
        for (int k = 0; k < int'(NCMT); k++) begin
            check($sformatf("cmt_valid%0d", k), 32'(bus.cmt_valid[k]), 32'(e_cmt_valid[k]));
            if (e_cmt_valid[k]) begin
                check($sformatf("cmt_rd%0d", k),  32'(bus.cmt_rd[k*5 +: 5]), 32'(e_cmt_rd[k]));
                check($sformatf("cmt_tag%0d", k), 32'(bus.cmt_tag[k*TAG_W +: TAG_W]), 32'(e_cmt_tag[k]));
                check($sformatf("cmt_val%0d", k), bus.cmt_val[k*32 +: 32], e_cmt_val[k]);
            end
        end
    endtask

    // Inputs are already driven at this negedge; one full clock follows.
    task automatic step();
        #1;
        check_comb();
        model_step();
        @(negedge clk);
        check_regs();
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic drive_random();
        int k;
        int t;
        idle();
        en = ($urandom_range(0, 9) != 0);
        reset = ($urandom_range(0, 299) == 0);
        if ($urandom_range(0, 3) != 0)
            set_alloc(op_e'(OP_W'($urandom_range(0, 5))), 5'($urandom), 4'($urandom));
        for (int j = 0; j < int'(NWB); j++) begin
            if (m_cnt > 0 && $urandom_range(0, 1) == 1) begin
                k = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(0, 32'(m_cnt - 1)));
                t = (m_head + k) % int'(DEPTH);
                if (m_op[t] != OP_STORE)
                    set_wb(j, t, $urandom, ctrl_op(m_op[t]) && $urandom_range(0, 5) == 0, $urandom);
            end
        end
        bus.q_valid = 2'($urandom);
        bus.q_tag[0] = TAG_W'($urandom);
        bus.q_tag[1] = TAG_W'($urandom);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        idle();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        model_step();
        check_regs();
        reset = 1'b0;

        // Four ALU ops written back in reverse order commit two per cycle in order.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            idle(); set_alloc(OP_ALU, 5'(i + 1), 4'd0); step();
        end
        for (int i = 3; i >= 0; i--) begin
            idle(); set_wb(0, i, 32'(32'h1000 + i), 1'b0, 32'd0); step();
        end
        idle(); step();
        check("A_pair0", 32'(bus.cmt_valid), 32'h3);
        check("A_tag1", 32'(bus.cmt_tag[TAG_W +: TAG_W]), 32'd1);
        idle(); step();
        check("A_tag3", 32'(bus.cmt_tag[TAG_W +: TAG_W]), 32'd3);
        check("A_count", 32'(bus.count), 32'd0);

        // Full buffer blocks alloc; one commit reopens it with the tail wrapped to 0.
        do_reset();
        for (int i = 0; i < int'(DEPTH); i++) begin
            idle(); set_alloc(OP_ALU, 5'(i), 4'd0); step();
        end
        #1 check("B_full_ready", 32'(bus.alloc_ready), 32'd0);
        idle(); set_wb(0, 0, 32'hAB, 1'b0, 32'd0); step();
        idle(); step();
        #1 check("B_reopen_ready", 32'(bus.alloc_ready), 32'd1);
        check("B_wrap_tag", 32'(bus.alloc_tag), 32'd0);

        // Redirecting BEQ at head commits alone and flushes everything behind it.
        do_reset();
        idle(); set_alloc(OP_BRANCH, 5'd0, 4'd0); step();
        idle(); set_alloc(OP_ALU, 5'd7, 4'd0); step();
        idle(); set_wb(0, 1, 32'h77, 1'b0, 32'd0); set_wb(1, 0, 32'd0, 1'b1, 32'h100); step();
        idle(); step();
        check("C_flush", 32'(bus.flush), 32'd1);
        check("C_flush_pc", bus.flush_pc, 32'h100);
        check("C_count", 32'(bus.count), 32'd0);
        check("C_no_cmt", 32'(bus.cmt_valid), 32'd0);

        // Two stores retire on consecutive cycles, one each.
        do_reset();
        idle(); set_alloc(OP_STORE, 5'd0, 4'd5); step();
        idle(); set_alloc(OP_STORE, 5'd0, 4'd9); step();
        check("D_st0", 32'(bus.st_commit), 32'd1);
        check("D_lsb0", 32'(bus.st_lsbpos), 32'd5);
        idle(); step();
        check("D_st1", 32'(bus.st_commit), 32'd1);
        check("D_lsb1", 32'(bus.st_lsbpos), 32'd9);

        // Query racing a same-cycle writeback.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            idle(); set_alloc(OP_ALU, 5'(i), 4'd0); step();
        end
        idle(); set_wb(0, 3, 32'h55, 1'b0, 32'd0);
        bus.q_valid = 2'b01; bus.q_tag[0] = 4'd3;
`ifdef ROB_WB_BYPASS_EN
        #1 check("E_q_ok", 32'(bus.q_ok[0]), 32'd1);
        check("E_q_val", bus.q_val[0], 32'h55);
`else
        #1 check("E_q_ok", 32'(bus.q_ok[0]), 32'd0);
`endif
        step();

        // Reset with live entries and a pending commit clears everything.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            idle(); set_alloc(OP_ALU, 5'(i), 4'd0); step();
        end
        idle(); set_wb(0, 0, 32'h9, 1'b0, 32'd0); step();
        idle(); reset = 1'b1; step();
        check("F_count", 32'(bus.count), 32'd0);
        check("F_pulses", 32'({bus.cmt_valid, bus.st_commit, bus.flush}), 32'd0);

        for (int n = 0; n < 3000; n++) begin
            drive_random();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
